// File: rtl/miner_pkg.sv
// Shared types and widths for the miner job controller.
package miner_pkg;

  localparam int HEADER_W = 608;
  localparam int TARGET_W = 256;
  localparam int NONCE_W  = 32;
  localparam int DATA_W   = 640;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/nonce_fifo.sv
// Small synchronous FIFO for found nonces. A push while full is dropped
// unless a pop happens in the same cycle, in which case both are performed.
module nonce_fifo
  import miner_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; storage cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/miner_scheduler.sv
// Job controller for the odo_keccak datapath: issues nonces, matches in-order
// results back to nonces, queues winners. Optional statistics counters are
// built only when MINER_SCHED_STATS_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for a job; results of an aborted job may still be dropping
//   RUN   | issuing nonces at the datapath rate
//   DRAIN | all nonces issued, waiting for outstanding results
module miner_scheduler
  import miner_pkg::*;
#(
  parameter int THROUGHPUT   = 1,
  parameter int INFLIGHT_MAX = 64,
  parameter int FOUND_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                work_valid,
  output logic                work_ready,
  input  logic [HEADER_W-1:0] work_header,
  input  logic [TARGET_W-1:0] work_target,
  input  logic [NONCE_W-1:0]  work_nonce_start,
  input  logic [NONCE_W-1:0]  work_nonce_end,
  input  logic                abort,
  output logic [DATA_W-1:0]   dp_data,
  output logic                dp_read,
  output logic [TARGET_W-1:0] dp_target,
  input  logic                dp_out,
  input  logic                dp_write,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NONCE_W-1:0]  res_nonce,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [47:0]         hash_count,
  output logic [15:0]         found_count
);

  localparam int IF_W  = $clog2(INFLIGHT_MAX + 1);
  localparam int IVL_W = (THROUGHPUT > 1) ? $clog2(THROUGHPUT) : 1;
  localparam logic [IVL_W-1:0] IVL_RELOAD = IVL_W'(THROUGHPUT - 1);

  state_t              state;
  logic [HEADER_W-1:0] header_q;
  logic [NONCE_W-1:0]  end_q, nonce_in, nonce_out, issue_nonce;
  logic [IF_W-1:0]     inflight, drop, inflight_nxt, drop_nxt;
  logic [IVL_W-1:0]    ivl_cnt;
  logic res_write, res_keep, drop_hit, room, accept, abort_act;
  logic issue, issue_last, fifo_push, fifo_full, fifo_empty;

  // Results arriving with nothing outstanding (e.g. after a reset mid-job) are ignored.
  // An in-cycle result frees a slot, so issue may resume the cycle after it.
  always_comb begin
    res_write    = dp_write && (inflight != '0);
    drop_hit     = res_write && (drop != '0);
    res_keep     = res_write && (drop == '0);
    room         = (inflight < IF_W'(INFLIGHT_MAX)) || res_write;
    accept       = (state == IDLE) && work_valid;
    abort_act    = abort && (state != IDLE);
    issue        = (accept && room) ||
                   ((state == RUN) && (ivl_cnt == '0) && room && !abort);
    issue_nonce  = accept ? work_nonce_start : nonce_in;
    issue_last   = (issue_nonce == (accept ? work_nonce_end : end_q));
    inflight_nxt = inflight + IF_W'(issue) - IF_W'(res_write);
    drop_nxt     = abort_act ? inflight_nxt : drop - IF_W'(drop_hit);
    fifo_push    = res_keep && dp_out;
  end

  assign work_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign res_valid  = !fifo_empty;

  // Sequencer: issue, in-flight/drop bookkeeping and result-to-nonce matching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      header_q  <= '0;
      end_q     <= '0;
      nonce_in  <= '0;
      nonce_out <= '0;
      inflight  <= '0;
      drop      <= '0;
      ivl_cnt   <= '0;
      dp_read   <= 1'b0;
      dp_data   <= '0;
      dp_target <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      dp_read  <= issue;
      done     <= 1'b0;
      inflight <= inflight_nxt;
      drop     <= drop_nxt;
      if (fifo_push && fifo_full && !res_ready) overflow <= 1'b1;
      if (res_keep) nonce_out <= nonce_out + 32'd1;
      if (issue) begin
        dp_data  <= {issue_nonce, accept ? work_header : header_q};
        nonce_in <= issue_nonce + 32'd1;
        ivl_cnt  <= IVL_RELOAD;
      end else if (ivl_cnt != '0) begin
        ivl_cnt  <= ivl_cnt - 1'b1;
      end
      case (state)
        IDLE: if (accept) begin
          header_q  <= work_header;
          dp_target <= work_target;
          end_q     <= work_nonce_end;
          nonce_out <= work_nonce_start;
          if (!issue) begin
            nonce_in <= work_nonce_start;
            ivl_cnt  <= '0;
          end
          state <= (issue && issue_last) ? DRAIN : RUN;
        end
        RUN: begin
          if (abort) state <= IDLE;
          else if (issue && issue_last) state <= DRAIN;
        end
        DRAIN: begin
          if (abort) state <= IDLE;
          else if ((inflight_nxt == '0) && (drop_nxt == '0)) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  nonce_fifo #(.WIDTH(NONCE_W), .DEPTH(FOUND_DEPTH)) u_found (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (res_ready),
    .din   (nonce_out),
    .dout  (res_nonce),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef MINER_SCHED_STATS_EN
  logic [47:0] hash_q;
  logic [15:0] found_q;
  logic        push_ok;

  assign push_ok = fifo_push && (!fifo_full || res_ready);

  // Saturating counters of kept results and successful pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_q  <= '0;
      found_q <= '0;
    end else begin
      if (res_keep && (hash_q != '1)) hash_q <= hash_q + 48'd1;
      if (push_ok && (found_q != '1)) found_q <= found_q + 16'd1;
    end
  end

  assign hash_count  = hash_q;
  assign found_count = found_q;
`else
  assign hash_count  = '0;
  assign found_count = '0;
`endif

endmodule

// File: doc/miner_scheduler.md
# miner_scheduler

Job controller for the `odo_keccak` hashing datapath. It latches one unit of work (header, target, inclusive nonce range) and issues nonces into the pipeline at the datapath's accepted rate. It matches in-order results back to their nonces and queues winning nonces in a small output FIFO. It sits between the host-facing work sources/probes and the `odo_keccak` worker, and supports abort with in-flight flush.

## Interface
- `THROUGHPUT`, default 1: cycles between successive issues; must equal the datapath's `THROUGHPUT`.
- `INFLIGHT_MAX`, default 64: maximum outstanding hashes.
- `FOUND_DEPTH`, default 4: depth of the found-nonce FIFO.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `work_valid`  in  1  new job offered
- `work_ready`  out  1  job accepted when both high
- `work_header`  in  608  block header, without nonce
- `work_target`  in  256  difficulty target
- `work_nonce_start`  in  32  first nonce, inclusive
- `work_nonce_end`  in  32  last nonce, inclusive
- `abort`  in  1  one-cycle pulse that cancels the current job
- `dp_data`  out  640  `{nonce, header}` to the datapath
- `dp_read`  out  1  one-cycle issue strobe
- `dp_target`  out  256  latched target
- `dp_out`  in  1  datapath result: 1 means hash < target
- `dp_write`  in  1  datapath result strobe; results return in order
- `res_valid`  out  1  found nonce available
- `res_ready`  in  1  consumer pops when both high
- `res_nonce`  out  32  found nonce
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse when a job completes naturally
- `overflow`  out  1  sticky; a find was lost because the FIFO was full
- `hash_count`  out  48  completed, non-dropped hashes
- `found_count`  out  16  finds pushed to the FIFO

## Operation

State machine:
- **IDLE**
  - `work_ready`=1.
  - On accept: latch header, target and end; set `nonce_in`=`nonce_out`=start; go to RUN.
- **RUN** issues when all of the following hold: the interval counter has expired, `inflight < INFLIGHT_MAX`, and `abort` is low.
  - On issue: `dp_read`=1, `dp_data={nonce_in, header}`, `inflight`++, `nonce_in`++ (32-bit wrap).
  - After issuing `nonce_in == end`, go to DRAIN.
- **DRAIN**
  - When `inflight==0` (and `drop==0`): pulse `done`, go to IDLE.
- **abort** in RUN or DRAIN:
  - `drop <= inflight` (net of a same-cycle `dp_write`), then go to IDLE.
  - `abort` is ignored in IDLE.

Range rules:
- `end == start`: exactly one nonce is issued.
- `end < start`: the range wraps through 0xFFFFFFFF→0.
- `end == start-1`: all 2^32 nonces are issued.

Result path, on each `dp_write`:
- `inflight`-- (an issue in the same cycle leaves it unchanged).
- If `drop > 0`: `drop`--, and the result is discarded; `nonce_out` is untouched.
- Otherwise, if `dp_out`=1, push `nonce_out` to the FIFO; then `nonce_out`++ (32-bit wrap).
- Push while the FIFO is full: the find is discarded, `overflow` is set, and the count is not incremented.

Job acceptance:
- A new job can be accepted in IDLE while `drop > 0`. Its results arrive only after the dropped ones.
- `drop` is decremented only by `dp_write`, including in IDLE.

FIFO:
- A pop and a push in the same cycle are both performed, including when the FIFO is full.
- `res_nonce` shows the head entry while `res_valid` is high.

## Timing
- Reset values:
  - State=IDLE, `work_ready`=1.
  - `dp_read`, `res_valid`, `done`, `overflow` = 0.
  - `dp_data`, `dp_target`, `res_nonce` = 0.
  - `hash_count`, `found_count` = 0.
  - `inflight`, `drop`, FIFO pointers = 0.
- Issue timing:
  - First `dp_read` is asserted the cycle after the accept.
  - Consecutive issues are at least `THROUGHPUT` cycles apart; with `THROUGHPUT`=1, one issue per cycle.
  - `dp_data`/`dp_target` are registered and valid in the same cycle as `dp_read`. They hold their value otherwise.
- Result timing:
  - `res_valid` rises the cycle after the qualifying `dp_write`.
  - `done` is pulsed the cycle after the last in-flight result retires.
- Stalls: when `inflight==INFLIGHT_MAX`, the issue is held until a `dp_write`. The interval counter saturates and does not reset.
- `rst_n` deassertion mid-job: the job is lost, and any results still emerging from the datapath are ignored. The datapath must be reset or drained externally before the next job is offered.

## Configuration
- With `MINER_SCHED_STATS_EN` defined:
  - `hash_count` increments on every non-dropped `dp_write`, saturating at 2^48-1.
  - `found_count` increments on every successful push, saturating.
- Without it: both outputs are tied to 0, with no counter logic instantiated.

## Structure
- Shared package `miner_pkg`:
  - Widths: HEADER_W=608, TARGET_W=256, NONCE_W=32, DATA_W=640.
  - State enum: IDLE/RUN/DRAIN.
- One sub-module, `nonce_fifo`: a synchronous FIFO parameterised by width and depth, with full/empty flags.
- Issue control, in-flight/drop counters and result matching stay in `miner_scheduler`.

## Test plan
- **Single nonce:** start=end=0x10; model returns `dp_out`=1 → exactly one `dp_read` with `dp_data[639:608]`=0x10; `res_nonce`=0x10; `done` pulses once.
- **Range, throughput:** `THROUGHPUT`=4, start=0, end=7, model latency 20, find on nonce 5 → `dp_read` every 4 cycles; 8 issues; only `res_nonce`=5 pushed; `hash_count`=8 with stats enabled.
- **Wrap:** start=0xFFFFFFFE, end=0x00000001 → nonces issued in the order FFFFFFFE, FFFFFFFF, 0, 1; then `done`.
- **Abort then new job:** abort with 10 in flight; new job start=0x100 accepted in IDLE; old results all report `dp_out`=1 → old results are not pushed; the first new result maps to 0x100.
- **Backpressure:** `INFLIGHT_MAX`=4, latency 50 → no more than 4 outstanding; issue resumes the cycle after `dp_write`.
- **FIFO overflow:** `FOUND_DEPTH`=4, `res_ready`=0, 6 finds → 4 entries, popped in order; `overflow`=1; `found_count`=4.
